// File: rtl/main_memory_ctrl_if.sv
// Request/response bundle for main_memory_ctrl: one line-wide request channel and
// one line-wide response channel, each with a valid/ready handshake.
interface main_memory_ctrl_if #(
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned WORDS_PER_LINE = 16,
  parameter int unsigned ADDR_W         = 5
);
  localparam int unsigned LineW = WORD_W * WORDS_PER_LINE;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [ADDR_W-1:0]         req_addr;
  logic [LineW-1:0]          req_wdata;
  logic [WORDS_PER_LINE-1:0] req_wmask;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [LineW-1:0]          resp_rdata;
  logic                      resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/main_memory_ctrl.sv
// Line-organised backing store: one outstanding request, fixed access latency,
// per-word write mask and out-of-range line detection.
module main_memory_ctrl #(
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned WORDS_PER_LINE = 16,
  parameter int unsigned LINE_COUNT     = 32,
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned ADDR_W         = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1
) (
  input logic               clk,
  input logic               rst_n,
  main_memory_ctrl_if.slave bus
);
  localparam int unsigned LineW   = WORD_W * WORDS_PER_LINE;
  localparam int unsigned Depth   = LINE_COUNT * WORDS_PER_LINE;
  localparam int unsigned IdxW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [7:0]  CntLoad = 8'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      write_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [LineW-1:0]          wdata_q;
  logic [WORDS_PER_LINE-1:0] wmask_q;
  logic [LineW-1:0]          rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic [WORD_W-1:0]         mem [Depth];
  logic [IdxW-1:0]           idx [WORDS_PER_LINE];
  logic [LineW-1:0]          line_merged;
  logic                      in_range, accept, do_access, do_write;

  assign accept    = (state_q == StIdle) && bus.req_valid;
  assign do_access = (state_q == StBusy) && (cnt_q == 8'd0);
  assign in_range  = 32'(addr_q) < LINE_COUNT;
  assign do_write  = do_access && write_q && in_range;

  // Merged line doubles as the read result: with write_q=0 every word comes from the array.
  always_comb begin
    line_merged = '0;
    for (int i = 0; i < int'(WORDS_PER_LINE); i++) begin
      idx[i] = IdxW'(32'(addr_q) * WORDS_PER_LINE + 32'(i));
      if (in_range) begin
        line_merged[i*WORD_W +: WORD_W] = (write_q && wmask_q[i]) ?
                                          wdata_q[i*WORD_W +: WORD_W] : mem[idx[i]];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          cnt_d   = CntLoad;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == 8'd0) begin
          rdata_d = in_range ? line_merged : '0;
          err_d   = !in_range;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StResp: begin
        if (bus.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        write_q <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        wmask_q <= bus.req_wmask;
      end
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < int'(WORDS_PER_LINE); i++) begin
        if (wmask_q[i]) mem[idx[i]] <= wdata_q[i*WORD_W +: WORD_W];
      end
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_main_memory_ctrl.sv
// Bench for main_memory_ctrl: a default-parameter instance and a small instance
// (16-bit words, 4 words/line, 20 lines, latency 1) checked against line-level models.
module tb_main_memory_ctrl;
  logic clk;
  logic rst_n;

  main_memory_ctrl_if #(.WORD_W(32), .WORDS_PER_LINE(16), .ADDR_W(5)) b0 ();
  main_memory_ctrl_if #(.WORD_W(16), .WORDS_PER_LINE(4), .ADDR_W(5)) b1 ();

  main_memory_ctrl d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  main_memory_ctrl #(
    .WORD_W(16), .WORDS_PER_LINE(4), .LINE_COUNT(20), .LATENCY(1)
  ) d1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  typedef struct {
    logic         w;
    logic [4:0]   a;
    logic [511:0] wd;
    logic [15:0]  m;
    logic [511:0] exp;
    logic         err;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [511:0] mdl0 [32];
  logic [63:0]  mdl1 [20];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

  task automatic chk_line(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b required %0b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [511:0] merge0(input logic [511:0] old, input logic [511:0] wd,
                                          input logic [15:0] m);
    logic [511:0] r = old;
    for (int i = 0; i < 16; i++) if (m[i]) r[32*i +: 32] = wd[32*i +: 32];
    return r;
  endfunction

  function automatic logic [63:0] merge1(input logic [63:0] old, input logic [63:0] wd,
                                         input logic [3:0] m);
    logic [63:0] r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[16*i +: 16] = wd[16*i +: 16];
    return r;
  endfunction

  // One transaction on d0; hold>0 keeps resp_ready low for that many cycles in RESP.
  task automatic txn0(input logic w, input logic [4:0] a, input logic [511:0] wd,
                      input logic [15:0] m, input int hold,
                      output logic [511:0] rd, output logic e);
    int k;
    @(negedge clk);
    b0.req_valid = 1'b1; b0.req_write = w; b0.req_addr = a;
    b0.req_wdata = wd; b0.req_wmask = m; b0.resp_ready = (hold == 0);
    k = 0;
    while (!b0.req_ready && k < 50) begin @(negedge clk); k++; end
    chk_bit("d0_accept_ready", b0.req_ready, 1'b1);
    @(negedge clk);
    b0.req_valid = 1'b0; b0.req_write = ~w; b0.req_addr = 5'($urandom);
    b0.req_wdata = {16{$urandom}}; b0.req_wmask = 16'($urandom);
    chk_bit("d0_busy_ready", b0.req_ready, 1'b0);
    k = 0;
    while (!b0.resp_valid && k < 300) begin @(negedge clk); k++; end
    chk_int("d0_latency", k, 4);
    rd = b0.resp_rdata;
    e  = b0.resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk_bit("d0_hold_valid", b0.resp_valid, 1'b1);
      chk_bit("d0_hold_ready", b0.req_ready, 1'b0);
      chk_line("d0_hold_data", b0.resp_rdata, rd);
    end
    b0.resp_ready = 1'b1;
    @(negedge clk);
    chk_bit("d0_resp_drop", b0.resp_valid, 1'b0);
    chk_bit("d0_ready_back", b0.req_ready, 1'b1);
  endtask

  task automatic txn1(input logic w, input logic [4:0] a, input logic [63:0] wd,
                      input logic [3:0] m, output logic [63:0] rd, output logic e);
    int k;
    @(negedge clk);
    b1.req_valid = 1'b1; b1.req_write = w; b1.req_addr = a;
    b1.req_wdata = wd; b1.req_wmask = m; b1.resp_ready = 1'b1;
    k = 0;
    while (!b1.req_ready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    b1.req_valid = 1'b0; b1.req_write = ~w; b1.req_addr = 5'($urandom);
    b1.req_wdata = {$urandom, $urandom}; b1.req_wmask = 4'($urandom);
    k = 0;
    while (!b1.resp_valid && k < 300) begin @(negedge clk); k++; end
    chk_int("d1_latency", k, 1);
    rd = b1.resp_rdata;
    e  = b1.resp_err;
    @(negedge clk);
    chk_bit("d1_ready_back", b1.req_ready, 1'b1);
  endtask

  initial begin
    vec_t v0[5];
    vec_t v1[5];
    logic [511:0] l1, la, lm, rd0, nd;
    logic [63:0]  rd1, l19, wd1;
    logic         e, w;
    logic [4:0]   a;
    logic [15:0]  m;
    int           k;

    rst_n = 1'b0;
    b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = '0;
    b0.req_wdata = '0; b0.req_wmask = '0; b0.resp_ready = 1'b0;
    b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = '0;
    b1.req_wdata = '0; b1.req_wmask = '0; b1.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_bit("reset_req_ready", b0.req_ready, 1'b1);
    chk_bit("reset_resp_valid", b0.resp_valid, 1'b0);
    chk_line("reset_rdata", b0.resp_rdata, '0);
    chk_bit("reset_err", b0.resp_err, 1'b0);

    for (int i = 0; i < 16; i++) begin
      l1[32*i +: 32] = 32'h1000 + 32'(i);
      la[32*i +: 32] = 32'hAAAA0000 + 32'(i);
      lm[32*i +: 32] = (i >= 4 && i <= 7) ? la[32*i +: 32] : l1[32*i +: 32];
    end
    v0[0] = '{w: 1'b1, a: 5'd3, wd: l1, m: 16'hFFFF, exp: l1, err: 1'b0};
    v0[1] = '{w: 1'b0, a: 5'd3, wd: {16{32'hDEAD0000}}, m: 16'hFFFF, exp: l1, err: 1'b0};
    v0[2] = '{w: 1'b1, a: 5'd3, wd: la, m: 16'h00F0, exp: lm, err: 1'b0};
    v0[3] = '{w: 1'b0, a: 5'd3, wd: '0, m: 16'h0000, exp: lm, err: 1'b0};
    v0[4] = '{w: 1'b1, a: 5'd3, wd: {16{32'h5555AAAA}}, m: 16'h0000, exp: lm, err: 1'b0};
    for (int t = 0; t < 5; t++) begin
      txn0(v0[t].w, v0[t].a, v0[t].wd, v0[t].m, 0, rd0, e);
      chk_line($sformatf("d0_vec%0d_data", t), rd0, v0[t].exp);
      chk_bit($sformatf("d0_vec%0d_err", t), e, v0[t].err);
    end

    txn0(1'b0, 5'd3, '0, 16'h0, 10, rd0, e);
    chk_line("d0_backpressure_data", rd0, lm);

    l19 = 64'hB003_B002_B001_B000;
    v1[0] = '{w: 1'b0, a: 5'd25, wd: '0, m: 16'h0, exp: '0, err: 1'b1};
    v1[1] = '{w: 1'b1, a: 5'd19, wd: 512'(l19), m: 16'hF, exp: 512'(l19), err: 1'b0};
    v1[2] = '{w: 1'b0, a: 5'd19, wd: '0, m: 16'h0, exp: 512'(l19), err: 1'b0};
    v1[3] = '{w: 1'b0, a: 5'd20, wd: '0, m: 16'h0, exp: '0, err: 1'b1};
    v1[4] = '{w: 1'b1, a: 5'd31, wd: 512'(64'h1234), m: 16'hF, exp: '0, err: 1'b1};
    for (int t = 0; t < 5; t++) begin
      txn1(v1[t].w, v1[t].a, v1[t].wd[63:0], v1[t].m[3:0], rd1, e);
      chk_line($sformatf("d1_vec%0d_data", t), 512'(rd1), v1[t].exp);
      chk_bit($sformatf("d1_vec%0d_err", t), e, v1[t].err);
    end

    // Back-to-back reads at LATENCY=1: accept, busy, resp, accept, ...
    @(negedge clk);
    b1.req_valid = 1'b1; b1.req_write = 1'b0; b1.req_addr = 5'd19; b1.resp_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      chk_bit("d1_b2b_ready", b1.req_ready, c % 3 == 0);
      chk_bit("d1_b2b_valid", b1.resp_valid, c % 3 == 2);
      if (c % 3 == 2) chk_line("d1_b2b_data", 512'(b1.resp_rdata), 512'(l19));
      @(negedge clk);
    end
    b1.req_valid = 1'b0;

    // Fill both models, then random traffic.
    for (int l = 0; l < 32; l++) begin
      nd = {16{$urandom}} ^ {$urandom, 480'd0};
      mdl0[l] = nd;
      txn0(1'b1, 5'(l), nd, 16'hFFFF, 0, rd0, e);
    end
    for (int l = 0; l < 20; l++) begin
      wd1 = {$urandom, $urandom};
      mdl1[l] = wd1;
      txn1(1'b1, 5'(l), wd1, 4'hF, rd1, e);
    end
    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom); a = 5'($urandom); m = 16'($urandom);
      for (int i = 0; i < 16; i++) nd[32*i +: 32] = $urandom;
      if (w) mdl0[a] = merge0(mdl0[a], nd, m);
      txn0(w, a, nd, m, 0, rd0, e);
      chk_line("d0_rand_data", rd0, mdl0[a]);
      chk_bit("d0_rand_err", e, 1'b0);
    end
    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom); a = 5'($urandom); m = 16'($urandom); wd1 = {$urandom, $urandom};
      txn1(w, a, wd1, m[3:0], rd1, e);
      if (a >= 20) begin
        chk_line("d1_rand_oor_data", 512'(rd1), '0);
        chk_bit("d1_rand_oor_err", e, 1'b1);
      end else begin
        if (w) mdl1[a] = merge1(mdl1[a], wd1, m[3:0]);
        chk_line("d1_rand_data", 512'(rd1), 512'(mdl1[a]));
        chk_bit("d1_rand_err", e, 1'b0);
      end
    end

    // Reset while a write to line 7 is in BUSY: write must be dropped.
    nd = ~mdl0[7];
    @(negedge clk);
    b0.req_valid = 1'b1; b0.req_write = 1'b1; b0.req_addr = 5'd7;
    b0.req_wdata = nd; b0.req_wmask = 16'hFFFF; b0.resp_ready = 1'b1;
    @(negedge clk);
    b0.req_valid = 1'b0;
    chk_bit("rst_busy_pre_ready", b0.req_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_bit("rst_busy_ready", b0.req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_bit("rst_busy_resp_valid", b0.resp_valid, 1'b0);
    chk_bit("rst_busy_req_ready", b0.req_ready, 1'b1);
    txn0(1'b0, 5'd7, '0, 16'h0, 0, rd0, e);
    chk_line("rst_busy_line7", rd0, mdl0[7]);

    // Reset while the write response is pending: write must stick.
    @(negedge clk);
    b0.req_valid = 1'b1; b0.req_write = 1'b1; b0.req_addr = 5'd7;
    b0.req_wdata = nd; b0.req_wmask = 16'hFFFF; b0.resp_ready = 1'b0;
    @(negedge clk);
    b0.req_valid = 1'b0;
    k = 0;
    while (!b0.resp_valid && k < 300) begin @(negedge clk); k++; end
    chk_bit("rst_resp_reached", b0.resp_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_bit("rst_resp_valid_clr", b0.resp_valid, 1'b0);
    chk_line("rst_resp_rdata_clr", b0.resp_rdata, '0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl0[7] = nd;
    txn0(1'b0, 5'd7, '0, 16'h0, 0, rd0, e);
    chk_line("rst_resp_line7", rd0, mdl0[7]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/main_memory_ctrl.md
# main_memory_ctrl

Parametrised line-organised main memory behind a valid/ready request/response handshake. It is the successor to the fixed 16×32-bit-word, 32-line memory: word width, words per line, line count and access latency are all configurable. It adds per-word write masking, address-range checking and a programmable access latency. It sits below the cache controller as the backing store, and one request is outstanding at a time.

## Interface
- WORD_W, 32, bits per memory word
- WORDS_PER_LINE, 16, words per line (transfer unit)
- LINE_COUNT, 32, number of lines; need not be a power of two
- LATENCY, 4, cycles from request acceptance to response; legal range 1..255
- ADDR_W, $clog2(LINE_COUNT) (min 1), line address width (derived, do not override)
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  line address
- req_wdata  input  WORD_W*WORDS_PER_LINE  write line; word i at bits [WORD_W*(i+1)-1 : WORD_W*i]
- req_wmask  input  WORDS_PER_LINE  per-word write enable; ignored on reads
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  WORD_W*WORDS_PER_LINE  line data, same word packing as req_wdata
- resp_err  output  1  request addressed a line >= LINE_COUNT

## Operation
- Storage: WORD_W-bit array of LINE_COUNT*WORDS_PER_LINE entries. Word i of line a lives at index a*WORDS_PER_LINE+i. Contents are not reset; they are undefined until written.
- FSM states are IDLE, BUSY and RESP.
  - IDLE: req_ready=1. When req_valid is high, capture req_write, req_addr, req_wdata and req_wmask, load a down-counter with LATENCY-1, and go to BUSY.
  - BUSY: req_ready=0. Decrement the counter each cycle. On the edge where the counter is 0, perform the access (below) and go to RESP.
  - RESP: resp_valid=1. resp_rdata and resp_err are stable and held until resp_valid && resp_ready. On that edge go to IDLE and drop resp_valid.
- Access is performed once, on the BUSY→RESP edge, using the captured request:
  - Address out of range (addr >= LINE_COUNT): no array access; resp_err=1, resp_rdata=0.
  - Read: resp_rdata = the full stored line; resp_err=0.
  - Write: each word i with mask[i]=1 is replaced by the corresponding word of wdata; unmasked words are unchanged. resp_rdata = the merged post-write line; resp_err=0.
  - A write with an all-zero mask is legal. It returns the current line and changes nothing.
- Input changes while the block is in BUSY or RESP have no effect; the request was captured on acceptance.

## Timing
- Reset values: req_ready=1 after reset is released, resp_valid=0, resp_rdata=0, resp_err=0, state=IDLE, counter=0.
- Request accepted at rising edge N, i.e. req_valid && req_ready sampled high.
- resp_valid rises after edge N+LATENCY. The write is visible in the array from that same edge.
- With resp_ready held high: response handshake at edge N+LATENCY+1, req_ready high again after that edge, next acceptance no earlier than edge N+LATENCY+2.
- Peak throughput is therefore one request per LATENCY+2 cycles. No request/response overlap.
- Backpressure: resp_valid stays high and resp_rdata/resp_err stay constant for any number of cycles while resp_ready=0.
- Reset mid-operation: rst_n low in BUSY or RESP returns the block immediately to IDLE and clears its outputs to the reset values.
  - A write still in BUSY is discarded; the array is unchanged.
  - A write already committed (state RESP) stays committed.

## Test plan
- Reset, then write line 3 with wdata word i = 0x1000+i and mask 0xFFFF (default params). Expect resp_valid exactly 4 cycles after acceptance, resp_err=0, and resp_rdata word i = 0x1000+i. Then read line 3 and expect identical data.
- Write line 3 with wdata word i = 0xAAAA0000+i and mask 0x00F0. Expect words 4..7 = 0xAAAA0004..0xAAAA0007 and all other words still 0x1000+i, in both the write response and a subsequent read.
- Hold resp_ready=0 for 10 cycles in RESP. Expect resp_valid and resp_rdata stable and req_ready=0 throughout. Release: handshake on the next edge and req_ready=1 one cycle later.
- LINE_COUNT=20: read line 25. Expect resp_err=1 and resp_rdata=0. A following read of line 19 returns resp_err=0.
- LATENCY=1: back-to-back reads with resp_ready=1. Expect acceptances exactly 3 cycles apart and each resp_valid exactly 1 cycle after its acceptance.
- Write line 7 then assert rst_n=0 while in BUSY. Expect resp_valid=0 and req_ready=1 after reset is released, and line 7 unchanged on readback. Repeat with reset asserted in RESP: expect the write retained.
